// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT datapath: frame geometry, the frame-loader
// state encoding and the bit-reverse helper that the loader and the
// twiddle/readback logic both use.
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_N_LOG2 = 10;
  localparam int FFT_DW     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } loader_state_e;

  // Reverse the low `width` bits of i; bits at or above `width` come back 0.
  // Bits are shifted out of i LSB-first and into r, so the first bit taken
  // (i[0]) ends up at r[width-1].
  function automatic logic [15:0] bitrev(input logic [15:0] i, input int width);
    logic [15:0] r;
    logic [15:0] v;
    r = 16'd0;
    v = i;
    for (int b = 0; b < 16; b++) begin
      if (b < width) begin
        r = {r[14:0], v[0]};
        v = {1'b0, v[15:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
// Write-side master for the FFT sample RAM. One frame of samples arrives on a
// valid/ready stream and each sample is written at its (optionally)
// bit-reversed index, so the butterfly engine produces natural-order output.
// A frame that ends early is zero-padded up to N samples. A wrong frame length
// sets a sticky error flag. frame_done pulses once all N locations are written.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               arm a frame load (only looked at in IDLE)
//   s_valid/s_data/
//   s_last/s_ready      sample stream, s_last marks the source's final sample
//   mem_we/mem_addr/
//   mem_data            RAM write port, one registered write per cycle
//   busy                frame in progress (LOAD, PAD, DONE)
//   frame_done          one-cycle pulse after the final RAM write
//   len_err             sticky length error, cleared by the next start
// -----------------------------------------------------------------------------
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int ADDR_W  = FFT_N_LOG2,
  parameter int DATA_W  = FFT_DW,
  parameter bit BIT_REV = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              frame_done,
  output logic              len_err
);

  // idx carries one spare bit so that N-1 + 1 never wraps back to 0.
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_e     state_q;
  logic [ADDR_W:0]   idx_q;
  logic              s_ready_q;
  logic              mem_we_q;
  logic [15:0]       mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              len_err_q;

  logic              accept_s;
  logic [15:0]       wr_addr_s;

  assign accept_s = s_valid && s_ready_q;

  // RAM address for the current index: bit-reversed or natural order.
  always_comb begin
    wr_addr_s = 16'd0;
    if (BIT_REV) begin
      wr_addr_s = bitrev(16'(idx_q[ADDR_W-1:0]), ADDR_W);
    end else begin
      wr_addr_s = 16'(idx_q[ADDR_W-1:0]);
    end
  end

  // Loader FSM with the index counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= {(ADDR_W+1){1'b0}};
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'd0;
      mem_data_q   <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      // Write enable and done are pulses; address/data hold their last value.
      mem_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // busy drops here, in the same cycle the frame_done pulse ends.
          busy_q <= 1'b0;
          if (start) begin
            state_q   <= ST_LOAD;
            idx_q     <= {(ADDR_W+1){1'b0}};
            len_err_q <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= wr_addr_s;
            mem_data_q <= s_data;
            idx_q      <= idx_q + IDX_ONE;
            if (idx_q == LAST_IDX) begin
              // Buffer full: a source that did not mark this beat last is too long.
              state_q   <= ST_DONE;
              s_ready_q <= 1'b0;
              if (!s_last) begin
                len_err_q <= 1'b1;
              end
            end else if (s_last) begin
              // Source ended short: fill the rest of the buffer with zeros.
              state_q   <= ST_PAD;
              s_ready_q <= 1'b0;
              len_err_q <= 1'b1;
            end
          end
        end
        ST_PAD: begin
          mem_we_q   <= 1'b1;
          mem_addr_q <= wr_addr_s;
          mem_data_q <= {DATA_W{1'b0}};
          idx_q      <= idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          frame_done_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_loader
// Drives a bit-reversed and a natural-order loader from the same stream.
// The expected write stream of a frame is built up front from the stimulus
// description (k-th write goes to rev(k) or k, carries sample k or zero past
// the source length). One tick task compares both instances every cycle.
// -----------------------------------------------------------------------------
module tb_fft_frame_loader;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic [1:0]  rdy;
  logic [1:0]  we;
  logic [1:0]  bsy;
  logic [1:0]  fd;
  logic [1:0]  le;
  logic [15:0] addr [2];
  logic [31:0] data [2];

  always #5 clk = ~clk;

  // index 0: natural order, index 1: bit-reversed order
  fft_frame_loader #(.ADDR_W(10), .DATA_W(32), .BIT_REV(1'b0)) dut_nat (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_data(data[0]), .busy(bsy[0]), .frame_done(fd[0]), .len_err(le[0]));

  fft_frame_loader #(.ADDR_W(10), .DATA_W(32), .BIT_REV(1'b1)) dut_rev (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_data(data[1]), .busy(bsy[1]), .frame_done(fd[1]), .len_err(le[1]));

  int          nvec;
  int          nfail;
  logic [31:0] exp_d [N];
  int          wr_cnt [2];
  bit          done_pend [2];
  int          done_cnt [2];
  bit          expect_wr;
  logic [31:0] ram [2][N];
  int          first_addr [4];

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 10; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  function automatic logic [31:0] exp_addr(input int inst, input int k);
    if (inst == 1) return 32'(brev(k));
    else return 32'(k);
  endfunction

  function automatic logic [31:0] pat(input int mode, input int k);
    case (mode)
      0:       return 32'(k);
      1:       return 32'h1000_0000 + 32'(k);
      default: return 32'hA5A5_0000 ^ (32'(k) * 32'd7);
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, got, exp, $time);
    end
  endtask

  // One clock cycle: compare both instances at the negedge, then move to
  // just after the next rising edge where the caller drives new inputs.
  task automatic tick(input int exp_rdy);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (exp_rdy >= 0) chk("s_ready", i, {31'd0, rdy[i]}, 32'(exp_rdy));
      chk("frame_done", i, {31'd0, fd[i]}, {31'd0, done_pend[i]});
      if (fd[i]) done_cnt[i]++;
      done_pend[i] = 1'b0;
      if (we[i]) begin
        if (!expect_wr || wr_cnt[i] >= N) begin
          chk("spurious_we", i, {31'd0, we[i]}, 32'd0);
        end else begin
          chk("mem_addr", i, {16'd0, addr[i]}, exp_addr(i, wr_cnt[i]));
          chk("mem_data", i, data[i], exp_d[wr_cnt[i]]);
          if (i == 1 && wr_cnt[i] < 4) first_addr[wr_cnt[i]] = int'(addr[i]);
          wr_cnt[i]++;
          done_pend[i] = (wr_cnt[i] == N);
        end
        ram[i][addr[i][9:0]] = data[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_s_ready"}, i, {31'd0, rdy[i]}, 32'd0);
      chk({name, "_mem_we"}, i, {31'd0, we[i]}, 32'd0);
      chk({name, "_mem_addr"}, i, {16'd0, addr[i]}, 32'd0);
      chk({name, "_mem_data"}, i, data[i], 32'd0);
      chk({name, "_busy"}, i, {31'd0, bsy[i]}, 32'd0);
      chk({name, "_frame_done"}, i, {31'd0, fd[i]}, 32'd0);
      chk({name, "_len_err"}, i, {31'd0, le[i]}, 32'd0);
    end
  endtask

  // Send one frame. len: source samples, give_last: mark sample len-1 as last,
  // gaps: random idle cycles between beats, start_mid: pulse start during
  // LOAD, abort_at: reset after that many beats (0 = never).
  task automatic run_frame(input int len, input bit give_last, input bit gaps,
                           input int mode, input bit start_mid, input int abort_at);
    int  done0;
    int  c;
    bit  exp_le;
    for (int k = 0; k < N; k++) exp_d[k] = (k < len) ? pat(mode, k) : 32'd0;
    exp_le = !(len == N && give_last);
    first_addr = '{-1, -1, -1, -1};
    wr_cnt     = '{0, 0};
    done_pend  = '{1'b0, 1'b0};
    expect_wr  = 1'b1;
    done0      = done_cnt[1];

    start = 1'b1;
    tick(0);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("busy_after_start", i, {31'd0, bsy[i]}, 32'd1);
      chk("len_err_cleared", i, {31'd0, le[i]}, 32'd0);
    end

    for (int k = 0; k < len; k++) begin
      if (abort_at != 0 && k == abort_at) begin
        #2 rst = 1'b1;
        #1 chk_all_zero("abort");
        expect_wr = 1'b0;
        wr_cnt    = '{0, 0};
        done_pend = '{1'b0, 1'b0};
        s_valid   = 1'b0;
        s_last    = 1'b0;
        tick(0);
        rst = 1'b0;
        repeat (8) tick(0);
        chk("no_done_after_abort", 1, 32'(done_cnt[1] - done0), 32'd0);
        return;
      end
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          s_valid = 1'b0;
          tick(1);
        end
      end
      s_valid = 1'b1;
      s_data  = pat(mode, k);
      s_last  = give_last && (k == len - 1);
      if (start_mid && k == 500) start = 1'b1;
      tick(1);
      start = 1'b0;
    end

    // Beats offered after the frame must not be taken.
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = 32'hDEAD_BEEF;
    repeat (3) tick(0);
    s_valid = 1'b0;

    c = 0;
    while (done_cnt[1] == done0 && c < 3000) begin
      tick(0);
      c++;
    end
    repeat (3) tick(0);
    for (int i = 0; i < 2; i++) begin
      chk("frame_done_count", i, 32'(done_cnt[i] - done0), 32'd1);
      chk("we_count", i, 32'(wr_cnt[i]), 32'(N));
      chk("len_err", i, {31'd0, le[i]}, {31'd0, exp_le});
      chk("busy_idle", i, {31'd0, bsy[i]}, 32'd0);
    end
    expect_wr = 1'b0;
  endtask

  initial begin
    nvec      = 0;
    nfail     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_data    = 32'd0;
    expect_wr = 1'b0;
    wr_cnt    = '{0, 0};
    done_pend = '{1'b0, 1'b0};
    done_cnt  = '{0, 0};
    first_addr = '{-1, -1, -1, -1};

    #2 chk_all_zero("reset");
    @(posedge clk);
    #1;
    tick(0);
    rst = 1'b0;
    // start is ignored... not asserted yet: s_valid alone must do nothing in IDLE
    s_valid = 1'b1;
    tick(0);
    tick(0);
    s_valid = 1'b0;

    // Full frame, natural stream, s_data = idx
    run_frame(N, 1'b1, 1'b0, 0, 1'b0, 0);
    chk("first_addr0", 1, 32'(first_addr[0]), 32'd0);
    chk("first_addr1", 1, 32'(first_addr[1]), 32'd512);
    chk("first_addr2", 1, 32'(first_addr[2]), 32'd256);
    chk("first_addr3", 1, 32'(first_addr[3]), 32'd768);
    chk("ram512", 1, ram[1][512], 32'd1);
    chk("ram1023", 1, ram[1][1023], 32'd1023);
    chk("nat_ram5", 0, ram[0][5], 32'd5);

    // Early s_last on idx 99: 100 data writes, 924 zero pads
    run_frame(100, 1'b1, 1'b0, 1, 1'b0, 0);
    chk("pad_ram152", 1, ram[1][152], 32'd0);
    chk("data_ram792", 1, ram[1][792], 32'h1000_0063);
    chk("nat_ram99", 0, ram[0][99], 32'h1000_0063);
    chk("nat_ram100", 0, ram[0][100], 32'd0);

    // Missing s_last: 1024 samples, none marked last
    run_frame(N, 1'b0, 1'b0, 2, 1'b0, 0);

    // Backpressure gaps plus a start pulse during LOAD
    run_frame(N, 1'b1, 1'b1, 2, 1'b1, 0);

    // Reset at idx 300, then a clean reload from idx 0
    run_frame(N, 1'b1, 1'b0, 1, 1'b0, 300);
    run_frame(N, 1'b1, 1'b0, 0, 1'b0, 0);
    chk("reload_addr0", 1, 32'(first_addr[0]), 32'd0);
    chk("reload_addr1", 1, 32'(first_addr[1]), 32'd512);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
